alu_sequencer: RTL and testbench

Two-requester scheduler and microsequencer for the shared 8-bit ALU datapath. It arbitrates round-robin between two operation requests. For the granted request it drives the 16-bit ControlSignals word plus register-file source/destination selects through a load/execute/writeback sequence on the shared DataBus. It sits between the instruction-level requesters and the ALU / register file.

---
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Two-requester round-robin scheduler and microsequencer for the shared 8-bit
// ALU datapath. The granted request's op and register selects are latched.
// The block then steps through LOADA (add/sub only), EXEC and WB, driving the
// ControlSignals word and the register-file selects.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   req0/req1      operation requests; held high until the matching gnt
//   op0/op1        ALU op: 00 add, 01 sub, 10 inc, 11 dec
//   a0/a1          register loaded into Data0 (add/sub only)
//   b0/b1          register driven onto DataBus as the ALU operand
//   d0/d1          destination register for the result
//   gnt            one-hot acceptance pulse, first cycle after the accept edge
//   done           one-hot completion pulse in the writeback cycle
//   busy           high whenever the sequencer is not IDLE
//   ControlSignals datapath control word
//   src_sel        register-file read select
//   dst_sel        register-file write select
//   dbg_state      current FSM state (IDLE=0, LOADA=1, EXEC=2, WB=3)
//
// Handshake: a request is accepted on a rising edge while IDLE and req is
// high. gnt pulses for exactly one cycle after that edge. req is sampled only
// in IDLE, so a requester that drops late is never granted twice.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [2:0]  a0,
  input  logic [2:0]  a1,
  input  logic [2:0]  b0,
  input  logic [2:0]  b1,
  input  logic [2:0]  d0,
  input  logic [2:0]  d1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        busy,
  output logic [15:0] ControlSignals,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADA = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_ptr;     // requester that wins a tie
  logic       r_win;     // requester owning the in-flight op
  logic       r_first;   // first cycle after an accept edge
  logic [1:0] r_op;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic [2:0] r_d;

  logic       w_g0;
  logic       w_g1;
  logic       w_accept;
  logic [1:0] w_win_oh;

  // Round-robin pick: a lone request wins; on a tie the pointer decides.
  always_comb begin
    w_g0     = req0 & (~req1 | ~r_ptr);
    w_g1     = req1 & (~req0 |  r_ptr);
    w_accept = (r_state == S_IDLE) & (w_g0 | w_g1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // inc/dec (op[1]=1) has no Data0 operand, so LOADA is skipped
          if (w_g1) w_next = op1[1] ? S_EXEC : S_LOADA;
          else      w_next = op0[1] ? S_EXEC : S_LOADA;
        end
      end
      S_LOADA: w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_first <= 1'b0;
      r_op    <= 2'd0;
      r_a     <= 3'd0;
      r_b     <= 3'd0;
      r_d     <= 3'd0;
    end else begin
      r_state <= w_next;
      r_first <= w_accept;
      if (w_accept) begin
        r_win <= w_g1;
        r_ptr <= ~w_g1;
        r_op  <= w_g1 ? op1 : op0;
        r_a   <= w_g1 ? a1  : a0;
        r_b   <= w_g1 ? b1  : b0;
        r_d   <= w_g1 ? d1  : d0;
      end
    end
  end

  // Outputs come only from the state register and latched fields.
  always_comb begin
    w_win_oh       = r_win ? 2'b10 : 2'b01;
    gnt            = r_first ? w_win_oh : 2'b00;
    done           = 2'b00;
    busy           = (r_state != S_IDLE);
    ControlSignals = 16'h0000;
    src_sel        = 3'd0;
    dst_sel        = 3'd0;
    dbg_state      = r_state;
    case (r_state)
      S_LOADA: begin
        ControlSignals = 16'h0028;               // src drives bus, Data0 loads
        src_sel        = r_a;
      end
      S_EXEC: begin
        ControlSignals = 16'h0108 | {14'd0, r_op}; // src drives bus, ALU computes
        src_sel        = r_b;
      end
      S_WB: begin
        ControlSignals = 16'h0014;               // ALU drives bus, regfile writes
        dst_sel        = r_d;
        done           = w_win_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [2:0]  a0, a1, b0, b1, d0, d1;
  logic [1:0]  gnt, done;
  logic        busy;
  logic [15:0] ControlSignals;
  logic [2:0]  src_sel, dst_sel;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  // {gnt, done, busy, ControlSignals, src_sel, dst_sel}
  logic [26:0] obs;
  assign obs = {gnt, done, busy, ControlSignals, src_sel, dst_sel};

  alu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .req1           (req1),
    .op0            (op0),
    .op1            (op1),
    .a0             (a0),
    .a1             (a1),
    .b0             (b0),
    .b1             (b1),
    .d0             (d0),
    .d1             (d1),
    .gnt            (gnt),
    .done           (done),
    .busy           (busy),
    .ControlSignals (ControlSignals),
    .src_sel        (src_sel),
    .dst_sel        (dst_sel),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic test_reset();
    logic [26:0] exp;
    reset = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0; d0 = 0; d1 = 0;
    @(negedge clk);
    @(negedge clk);
    exp = 27'd0;
    n_vec++;
    if (obs !== exp || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got %h/%0d exp %h/0", obs, dbg_state, exp);
    end
    reset = 1'b1;
    // start an add, then assert reset in the middle of EXEC
    req0 = 1; op0 = 2'b00; a0 = 3'd1; b0 = 3'd2; d0 = 3'd3;
    @(negedge clk);                 // cycle 1 (LOADA)
    req0 = 0;
    @(negedge clk);                 // cycle 2 (EXEC)
    exp = {2'b00, 2'b00, 1'b1, 16'h0108, 3'd2, 3'd0};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_pre_exec got %h exp %h", obs, exp);
    end
    reset = 1'b0;
    #1;
    exp = 27'd0;
    n_vec++;
    if (obs !== exp || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_exec got %h/%0d exp %h/0", obs, dbg_state, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    // discarded op must not produce done; pointer must be back at 0
    @(negedge clk);
    n_vec++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL reset_no_done got %h exp 0", obs);
    end
    req0 = 1; req1 = 1; op0 = 2'b10; op1 = 2'b10;
    @(negedge clk);
    req0 = 0; req1 = 0;
    n_vec++;
    if (gnt !== 2'b01) begin
      n_err++;
      $display("FAIL reset_ptr got gnt %b exp 01", gnt);
    end
    @(negedge clk);                 // WB of inc for requester 0
    @(negedge clk);                 // IDLE, pointer now at 1
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drain got busy %b exp 0", busy);
    end
    // bring pointer back to 0 with a lone requester-1 op
    req1 = 1; op1 = 2'b10;
    @(negedge clk);
    req1 = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_single_add();
    logic [26:0] exp;
    req0 = 1; op0 = 2'b00; a0 = 3'd1; b0 = 3'd2; d0 = 3'd3;
    @(negedge clk);
    req0 = 0;
    exp = {2'b01, 2'b00, 1'b1, 16'h0028, 3'd1, 3'd0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL add_c1 got %h exp %h", obs, exp); end
    @(negedge clk);
    exp = {2'b00, 2'b00, 1'b1, 16'h0108, 3'd2, 3'd0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL add_c2 got %h exp %h", obs, exp); end
    @(negedge clk);
    exp = {2'b00, 2'b01, 1'b1, 16'h0014, 3'd0, 3'd3};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL add_c3 got %h exp %h", obs, exp); end
    @(negedge clk);
    exp = 27'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL add_c4 got %h exp %h", obs, exp); end
  endtask

  task automatic test_single_dec();
    logic [26:0] exp;
    req1 = 1; op1 = 2'b11; a1 = 3'd7; b1 = 3'd5; d1 = 3'd6;
    @(negedge clk);
    req1 = 0;
    exp = {2'b10, 2'b00, 1'b1, 16'h010B, 3'd5, 3'd0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL dec_c1 got %h exp %h", obs, exp); end
    @(negedge clk);
    exp = {2'b00, 2'b10, 1'b1, 16'h0014, 3'd0, 3'd6};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL dec_c2 got %h exp %h", obs, exp); end
    @(negedge clk);
    exp = 27'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL dec_c3 got %h exp %h", obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic [1:0] e;
    int cyc;
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    req0 = 1; op0 = 2'b00; a0 = 3'd1; b0 = 3'd2; d0 = 3'd3;
    req1 = 1; op1 = 2'b10; b1 = 3'd4; d1 = 3'd5;
    cyc = 0;
    while (got_q.size() < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt !== 2'b00) got_q.push_back(gnt);
    end
    req0 = 0; req1 = 0;
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL rr_timeout got %0d grants exp 4", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (got_q[0] !== e) begin
        n_err++;
        $display("FAIL rr_order got gnt %b exp %b", got_q[0], e);
      end
      void'(got_q.pop_front());
    end
    cyc = 0;
    while (busy && cyc < 10) begin @(negedge clk); cyc++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rr_drain got busy %b exp 0", busy); end
  endtask

  task automatic test_late_drop();
    int n_gnt, n_done, since;
    n_gnt = 0; n_done = 0; since = -1;
    req0 = 1; op0 = 2'b01; a0 = 3'd2; b0 = 3'd4; d0 = 3'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt[0]) begin n_gnt++; since = 0; end
      else if (since >= 0) since++;
      if (done[0]) n_done++;
      if (since == 2) req0 = 0;
    end
    req0 = 0;
    n_vec++;
    if (n_gnt != 1) begin n_err++; $display("FAIL late_gnt got %0d exp 1", n_gnt); end
    n_vec++;
    if (n_done != 1) begin n_err++; $display("FAIL late_done got %0d exp 1", n_done); end
  endtask

  task automatic test_bus_exclusivity();
    int n_gnt, n_done, cyc;
    n_gnt = 0; n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_vec++;
      if ((ControlSignals[2] && ControlSignals[3]) || ((ControlSignals & 16'hFEC0) != 16'h0000)
          || ((gnt & done) != 2'b00)) begin
        n_err++;
        $display("FAIL bus_excl got ctrl %h gnt %b done %b", ControlSignals, gnt, done);
      end
      n_gnt  += int'(gnt[0]) + int'(gnt[1]);
      n_done += int'(done[0]) + int'(done[1]);
      if (gnt[0]) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; op0 = 2'($urandom_range(0, 3));
        a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7)); d0 = 3'($urandom_range(0, 7));
      end
      if (gnt[1]) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; op1 = 2'($urandom_range(0, 3));
        a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7)); d1 = 3'($urandom_range(0, 7));
      end
    end
    // let any pending request be granted and finish, then stop issuing
    cyc = 0;
    while ((req0 || req1 || busy) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      n_gnt  += int'(gnt[0]) + int'(gnt[1]);
      n_done += int'(done[0]) + int'(done[1]);
      if (gnt[0]) req0 = 0;
      if (gnt[1]) req1 = 0;
    end
    n_vec++;
    if (n_gnt != n_done || n_gnt == 0) begin
      n_err++;
      $display("FAIL bus_balance got gnt %0d done %0d exp equal nonzero", n_gnt, n_done);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_add();
    test_single_dec();
    test_round_robin();
    test_late_drop();
    test_bus_exclusivity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
